// File: rtl/taxi_i2c_target_reg.sv
`default_nettype none
// ============================================================================
// Module      : taxi_i2c_target_reg
// Description : I2C target (slave) exposing a byte-wide register interface.
//               A write of [addr+W][ptr][data...] loads the register pointer
//               and strobes reg_wr_en once per data byte, with the pointer
//               auto-incrementing. A read of [addr+R] strobes reg_rd_en,
//               captures reg_rd_data and shifts it out MSB first, continuing
//               while the controller ACKs.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               scl_i, sda_i        - raw bus levels (asynchronous to clk)
//               sda_o               - open-drain SDA drive (1 = release)
//               reg_addr            - register pointer
//               reg_wr_data/_en     - write byte and one-cycle write strobe
//               reg_rd_en           - one-cycle read request
//               reg_rd_data         - read byte, valid the cycle after
//                                     the reg_rd_en cycle
//               busy                - high from START until STOP
// Config      : `define TAXI_I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN
//               cycle stability filter behind the synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_i2c_target_reg #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_ADDR     = 4'd1;
    localparam logic [3:0] c_ADDR_ACK = 4'd2;
    localparam logic [3:0] c_WR_PTR   = 4'd3;
    localparam logic [3:0] c_WR_DATA  = 4'd4;
    localparam logic [3:0] c_WR_ACK   = 4'd5;
    localparam logic [3:0] c_RD_DATA  = 4'd6;
    localparam logic [3:0] c_RD_ACK   = 4'd7;
    localparam logic [3:0] c_IGNORE   = 4'd8;

    // ---------------- input synchronizers ----------------
    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic w_scl, w_sda;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef TAXI_I2C_TARGET_GLITCH_FILTER_EN
    localparam int c_FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             r_scl_f, r_sda_f;
    logic [c_FCW-1:0] r_scl_fcnt, r_sda_fcnt;

    // The filtered level follows the synchronized level only after it has
    // disagreed for FILTER_LEN consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_fcnt <= '0;
            r_sda_fcnt <= '0;
        end else begin
            if (r_scl_s2 == r_scl_f) begin
                r_scl_fcnt <= '0;
            end else if (r_scl_fcnt == c_FCW'(FILTER_LEN - 1)) begin
                r_scl_f    <= r_scl_s2;
                r_scl_fcnt <= '0;
            end else begin
                r_scl_fcnt <= r_scl_fcnt + 1'b1;
            end

            if (r_sda_s2 == r_sda_f) begin
                r_sda_fcnt <= '0;
            end else if (r_sda_fcnt == c_FCW'(FILTER_LEN - 1)) begin
                r_sda_f    <= r_sda_s2;
                r_sda_fcnt <= '0;
            end else begin
                r_sda_fcnt <= r_sda_fcnt + 1'b1;
            end
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    logic w_unused_filter_len;

    assign w_unused_filter_len = (FILTER_LEN > 0);
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // ---------------- bus event detection ----------------
    logic r_scl_d, r_sda_d;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;

    // ---------------- protocol FSM ----------------
    logic [3:0] r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [7:0] r_ptr, w_ptr_nx;
    logic [7:0] r_wr_data, w_wr_data_nx;
    logic       r_sda, w_sda_nx;
    logic       r_wr_en, w_wr_en_nx;
    logic       r_rd_en, w_rd_en_nx;
    logic       r_rd_cap, w_rd_cap_nx;
    logic       r_rw, w_rw_nx;
    logic       r_busy, w_busy_nx;
    logic [2:0] w_bit_idx;

    // Bit to present on the next SCL low phase while shifting a read byte.
    assign w_bit_idx = 3'd7 - r_cnt[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_wr_data <= 8'h00;
            r_sda     <= 1'b1;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_cap  <= 1'b0;
            r_rw      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_shift   <= w_shift_nx;
            r_ptr     <= w_ptr_nx;
            r_wr_data <= w_wr_data_nx;
            r_sda     <= w_sda_nx;
            r_wr_en   <= w_wr_en_nx;
            r_rd_en   <= w_rd_en_nx;
            r_rd_cap  <= w_rd_cap_nx;
            r_rw      <= w_rw_nx;
            r_busy    <= w_busy_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_shift_nx   = r_shift;
        w_ptr_nx     = r_ptr;
        w_wr_data_nx = r_wr_data;
        w_sda_nx     = r_sda;
        w_wr_en_nx   = 1'b0;
        w_rd_en_nx   = 1'b0;
        w_rd_cap_nx  = r_rd_en;
        w_rw_nx      = r_rw;
        w_busy_nx    = r_busy;

        // Pointer advances the cycle after a write strobe so the strobe
        // itself carries the pre-increment address.
        if (r_wr_en) begin
            w_ptr_nx = r_ptr + 8'd1;
        end
        // Read data is taken the cycle after the reg_rd_en cycle.
        if (r_rd_cap) begin
            w_shift_nx = reg_rd_data;
        end

        if (w_stop) begin
            w_state_nx  = c_IDLE;
            w_cnt_nx    = 4'd0;
            w_sda_nx    = 1'b1;
            w_busy_nx   = 1'b0;
            w_rd_cap_nx = 1'b0;
        end else if (w_start) begin
            w_state_nx  = c_ADDR;
            w_cnt_nx    = 4'd0;
            w_sda_nx    = 1'b1;
            w_busy_nx   = 1'b1;
            w_rd_cap_nx = 1'b0;
        end else begin
            case (r_state)
                c_ADDR, c_WR_PTR, c_WR_DATA: begin
                    if (w_scl_rise && (r_cnt < 4'd8)) begin
                        w_shift_nx = {r_shift[6:0], w_sda};
                        w_cnt_nx   = r_cnt + 4'd1;
                    end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                        w_cnt_nx = 4'd0;
                        if (r_state == c_ADDR) begin
                            if (r_shift[7:1] == TARGET_ADDR) begin
                                w_state_nx = c_ADDR_ACK;
                                w_sda_nx   = 1'b0;
                                w_rw_nx    = r_shift[0];
                            end else begin
                                w_state_nx = c_IGNORE;
                                w_sda_nx   = 1'b1;
                            end
                        end else if (r_state == c_WR_PTR) begin
                            w_ptr_nx   = r_shift;
                            w_state_nx = c_WR_ACK;
                            w_sda_nx   = 1'b0;
                        end else begin
                            w_wr_en_nx   = 1'b1;
                            w_wr_data_nx = r_shift;
                            w_state_nx   = c_WR_ACK;
                            w_sda_nx     = 1'b0;
                        end
                    end
                end
                c_ADDR_ACK: begin
                    if (w_scl_rise && r_rw) begin
                        w_rd_en_nx = 1'b1;
                    end else if (w_scl_fall) begin
                        w_cnt_nx = 4'd0;
                        if (r_rw) begin
                            w_state_nx = c_RD_DATA;
                            w_sda_nx   = r_shift[7];
                        end else begin
                            w_state_nx = c_WR_PTR;
                            w_sda_nx   = 1'b1;
                        end
                    end
                end
                c_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nx = c_WR_DATA;
                        w_sda_nx   = 1'b1;
                        w_cnt_nx   = 4'd0;
                    end
                end
                c_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_nx = c_RD_ACK;
                            w_sda_nx   = 1'b1;
                            w_cnt_nx   = 4'd0;
                        end else begin
                            w_sda_nx = r_shift[w_bit_idx];
                        end
                    end
                end
                c_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_nx = r_ptr + 8'd1;
                        if (!w_sda) begin
                            w_rd_en_nx = 1'b1;
                        end else begin
                            w_state_nx = c_IGNORE;
                        end
                    end else if (w_scl_fall) begin
                        w_state_nx = c_RD_DATA;
                        w_sda_nx   = r_shift[7];
                        w_cnt_nx   = 4'd0;
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for START/STOP only.
                end
            endcase
        end
    end

    assign sda_o       = r_sda;
    assign reg_addr    = r_ptr;
    assign reg_wr_data = r_wr_data;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_taxi_i2c_target_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_taxi_i2c_target_reg
// Description : Self-checking bench for taxi_i2c_target_reg. A behavioural
//               I2C controller drives the bus; a small register model answers
//               read requests; write strobes and read requests are logged.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_i2c_target_reg;

    localparam int Q = 10; // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_o;
    logic       sda_line;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    logic       reg_wr_en, reg_rd_en, busy;

    int n_checks = 0;
    int n_errors = 0;
    int viol     = 0;

    logic [7:0]  mem [256];
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;

    always #5 clk = ~clk;

    assign sda_line = sda_c & sda_o;

    taxi_i2c_target_reg #(
        .TARGET_ADDR (7'h50),
        .FILTER_LEN  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_c),
        .sda_i       (sda_line),
        .sda_o       (sda_o),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    // Register model: data valid only in the cycle after the request cycle.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];
        else           reg_rd_data <= 8'hEE;
    end

    // Strobe logging and strobe-rule monitoring.
    always @(negedge clk) begin
        if (reg_wr_en) wr_q.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en) rd_q.push_back(reg_addr);
        if (reg_wr_en && reg_rd_en) viol++;
        if (reg_wr_en && prev_wr)   viol++;
        if (reg_rd_en && prev_rd)   viol++;
        prev_wr = reg_wr_en;
        prev_rd = reg_rd_en;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_c = 1'b1; wait_clk(Q);
        scl_c = 1'b1; wait_clk(Q);
        sda_c = 1'b0; wait_clk(Q);
        scl_c = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; wait_clk(Q);
        scl_c = 1'b1; wait_clk(Q);
        sda_c = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch, output logic seen);
        sda_c = b;
        wait_clk(Q);
        scl_c = 1'b1;
        if (glitch) begin
            wait_clk(3);
            scl_c = 1'b0;
            wait_clk(2);
            scl_c = 1'b1;
            wait_clk(Q - 5);
        end else begin
            wait_clk(Q);
        end
        seen = sda_line;
        wait_clk(Q);
        scl_c = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic seen;
        for (int i = 0; i < 8; i++) send_bit(d[7-i], (glitch_bit == i), seen);
        send_bit(1'b1, 1'b0, seen);
        ack = ~seen;
    endtask

    task automatic read_byte(input logic ctrl_ack, output logic [7:0] d);
        logic seen;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0, seen);
            d = {d[6:0], seen};
        end
        send_bit(~ctrl_ack, 1'b0, seen);
    endtask

    typedef struct {
        logic [7:0] dev, ptr, d0, d1;
        logic [3:0] exp_ack;
        int         exp_nwr;
        logic [15:0] w0, w1;
    } wvec_t;

    wvec_t tbl[4];

    initial begin
        logic [3:0] acks;
        logic       a;
        logic [7:0] rb;
        logic       seen;
        logic [7:0] glitch_exp;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;

        tbl[0] = '{dev:8'hA0, ptr:8'h10, d0:8'h5A, d1:8'hC3, exp_ack:4'b1111, exp_nwr:2, w0:16'h105A, w1:16'h11C3};
        tbl[1] = '{dev:8'hA2, ptr:8'h10, d0:8'h5A, d1:8'hC3, exp_ack:4'b0000, exp_nwr:0, w0:16'h0000, w1:16'h0000};
        tbl[2] = '{dev:8'hA0, ptr:8'h40, d0:8'h00, d1:8'hFF, exp_ack:4'b1111, exp_nwr:2, w0:16'h4000, w1:16'h41FF};
        tbl[3] = '{dev:8'hA0, ptr:8'hFF, d0:8'h01, d1:8'h02, exp_ack:4'b1111, exp_nwr:2, w0:16'hFF01, w1:16'h0002};

        // ---- reset state ----
        wait_clk(3);
        check("rst_sda_o", sda_o, 1);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_rd_en", reg_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_wr_data", reg_wr_data, 8'h00);
        rst = 1'b0;
        wait_clk(1);
        check("post_rst_sda_o", sda_o, 1);
        check("post_rst_busy", busy, 0);
        wait_clk(Q);

        // ---- table-driven write transactions ----
        for (int v = 0; v < 4; v++) begin
            wr_q.delete();
            i2c_start();
            check($sformatf("v%0d_busy_start", v), busy, 1);
            write_byte(tbl[v].dev, -1, acks[3]);
            write_byte(tbl[v].ptr, -1, acks[2]);
            write_byte(tbl[v].d0,  -1, acks[1]);
            write_byte(tbl[v].d1,  -1, acks[0]);
            i2c_stop();
            check($sformatf("v%0d_acks", v), acks, tbl[v].exp_ack);
            check($sformatf("v%0d_nwr", v), wr_q.size(), tbl[v].exp_nwr);
            if (tbl[v].exp_nwr == 2 && wr_q.size() == 2) begin
                check($sformatf("v%0d_wr0", v), wr_q[0], tbl[v].w0);
                check($sformatf("v%0d_wr1", v), wr_q[1], tbl[v].w1);
            end
            check($sformatf("v%0d_busy_stop", v), busy, 0);
        end

        // ---- pointer write, repeated START, read with ACK then NACK ----
        rd_q.delete();
        wr_q.delete();
        i2c_start();
        write_byte(8'hA0, -1, a); check("rd_dev_w_ack", a, 1);
        write_byte(8'h20, -1, a); check("rd_ptr_ack", a, 1);
        i2c_start();
        write_byte(8'hA1, -1, a); check("rd_dev_r_ack", a, 1);
        read_byte(1'b1, rb);      check("rd_byte0", rb, 8'h11);
        read_byte(1'b0, rb);      check("rd_byte1", rb, 8'h22);
        check("rd_sda_released", sda_o, 1);
        send_bit(1'b1, 1'b0, seen);
        check("rd_ignore_after_nack", seen, 1);
        check("rd_req_count", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            check("rd_req_addr0", rd_q[0], 8'h20);
            check("rd_req_addr1", rd_q[1], 8'h21);
        end
        check("rd_ptr_after", reg_addr, 8'h22);
        check("rd_no_writes", wr_q.size(), 0);
        i2c_stop();
        check("rd_busy_stop", busy, 0);

        // ---- reset in the middle of a data byte ----
        wr_q.delete();
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h30, -1, a);
        for (int i = 0; i < 4; i++) send_bit((i != 1), 1'b0, seen);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("mid_rst_sda_o", sda_o, 1);
        check("mid_rst_busy", busy, 0);
        wait_clk(Q);
        check("mid_rst_no_write", wr_q.size(), 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, -1, acks[3]);
        write_byte(8'h60, -1, acks[2]);
        write_byte(8'h77, -1, acks[1]);
        write_byte(8'h88, -1, acks[0]);
        i2c_stop();
        check("after_rst_acks", acks, 4'b1111);
        check("after_rst_nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("after_rst_wr0", wr_q[0], 16'h6077);
            check("after_rst_wr1", wr_q[1], 16'h6188);
        end

        // ---- 2-clk SCL low glitch inside a data byte ----
`ifdef TAXI_I2C_TARGET_GLITCH_FILTER_EN
        glitch_exp = 8'h5A;
`else
        glitch_exp = 8'h2D;
`endif
        wr_q.delete();
        i2c_start();
        write_byte(8'hA0, -1, a);
        write_byte(8'h30, -1, a);
        write_byte(8'h5A, 0, a);
        i2c_stop();
        check("glitch_nwr", wr_q.size(), 1);
        if (wr_q.size() == 1) check("glitch_wr", wr_q[0], {8'h30, glitch_exp});

        check("strobe_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/taxi_i2c_target_reg.md
TAXI_I2C_TARGET_REG -- requirements
Module: taxi_i2c_target_reg

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50, 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter FILTER_LEN, default 4, number of clk cycles an input level must be stable before it is accepted (used only under REQ-027).
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl_i  input  1  bus SCL level; asynchronous to clk.
REQ-006 sda_i  input  1  bus SDA level; asynchronous to clk.
REQ-007 sda_o  output  1  open-drain SDA drive; 1 = release, 0 = pull low.
REQ-008 reg_addr  output  8  register pointer for the current access.
REQ-009 reg_wr_data  output  8  write byte, valid while reg_wr_en=1.
REQ-010 reg_wr_en  output  1  one-cycle write strobe.
REQ-011 reg_rd_en  output  1  one-cycle read request.
REQ-012 reg_rd_data  input  8  read byte, sampled exactly one clk after reg_rd_en.
REQ-013 busy  output  1  high from an accepted START until the next STOP.

Function
REQ-014 scl_i/sda_i SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized (and filtered, if enabled) levels.
REQ-015 START = SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be detected in any state and override the current state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 START -> ADDR, bit counter cleared; STOP -> IDLE, sda_o=1; repeated START SHALL keep the register pointer.
REQ-018 Data bits SHALL be sampled on SCL rising edge, MSB first; sda_o SHALL change only on the clk after a detected SCL falling edge.
REQ-019 ADDR: after 8 bits, address match -> ADDR_ACK driving sda_o=0 for the 9th SCL period; mismatch -> IGNORE with sda_o=1 (NACK).
REQ-020 ADDR_ACK, R/W=0: next byte -> WR_PTR, loaded into the pointer, ACKed; following bytes -> WR_DATA.
REQ-021 Each complete WR_DATA byte SHALL pulse reg_wr_en for one clk at the SCL falling edge following bit 8, with reg_addr=pointer and reg_wr_data=byte; the byte SHALL be ACKed; the pointer SHALL then increment modulo 256 (8'hFF -> 8'h00).
REQ-022 ADDR_ACK, R/W=1: reg_rd_en SHALL pulse on the 9th SCL rising edge; reg_rd_data SHALL be captured one clk later into the shift register; MSB SHALL drive on the falling edge ending the ACK bit.
REQ-023 RD_DATA: 8 bits shifted out, then sda_o released for RD_ACK; controller ACK (SDA=0 at 9th rising edge) -> pointer increments, reg_rd_en pulses for the new pointer, next byte; NACK -> IGNORE, pointer incremented.
REQ-024 IGNORE SHALL hold sda_o=1 and emit no strobes until START or STOP.
REQ-025 reg_wr_en and reg_rd_en SHALL never be high in the same cycle, and each SHALL never be high on two consecutive cycles.

Reset
REQ-026 While rst=1 and on the following cycle: state IDLE, sda_o=1, reg_wr_en=0, reg_rd_en=0, busy=0, reg_addr=8'h00, reg_wr_data=8'h00, bit counter=0, synchronizer/filter state=1. Reset mid-transaction SHALL release SDA within one clk and ignore the bus until the next START.

Configuration
REQ-027 Macro TAXI_I2C_TARGET_GLITCH_FILTER_EN: defined -> each synchronized input SHALL update only after FILTER_LEN consecutive equal samples; undefined -> no filter, inputs used directly after the 2-flop synchronizer, FILTER_LEN unused.

Verification
REQ-028 Write 0xA0, 0x10, 0x5A, 0xC3, STOP -> four ACKs; reg_wr_en at (0x10, 0x5A) then (0x11, 0xC3); busy low after STOP.
REQ-029 Write 0xA0, 0x20; repeated START 0xA1; reg_rd_data returns 0x11 then 0x22; controller ACK then NACK -> bus reads 0x11, 0x22; reg_rd_en at 0x20, 0x21; SDA released; IGNORE until STOP.
REQ-030 Address 0xA2 (0x51 write) -> sda_o stays 1 at the 9th clock; no reg strobes; next START to 0x50 is ACKed.
REQ-031 Pointer 0xFF, write 0x01, 0x02 -> writes at 0xFF then 0x00.
REQ-032 rst asserted at bit 4 of a data byte -> sda_o=1 next clk; no strobe; a following full write transaction completes normally.
REQ-033 FILTER_LEN=4, 2-clk SCL low glitch during a byte -> macro defined: ignored, byte correct; macro undefined: counted as an extra bit, byte shifted.
